// File: rtl/conv_line_buffer.sv
// Raster-to-column line buffer: keeps KERNEL_SIZE-1 previous lines and emits one vertical
// KERNEL_SIZE-pixel column per accepted pixel once enough lines are buffered.
module conv_line_buffer #(
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned IMG_WIDTH   = 32,
    parameter int unsigned IMG_HEIGHT  = 32,
    localparam int unsigned X_W        = $clog2(IMG_WIDTH)
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              clear,
    input  logic [DATA_WIDTH-1:0]             in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [DATA_WIDTH*KERNEL_SIZE-1:0] col_data,
    output logic                              col_valid,
    input  logic                              col_ready,
    output logic [X_W-1:0]                    col_x,
    output logic                              col_eol,
    output logic                              frame_done
);

    localparam int unsigned Y_W   = $clog2(IMG_HEIGHT);
    localparam int unsigned LINES = KERNEL_SIZE - 1;

    logic [DATA_WIDTH-1:0]             r_mem [LINES][IMG_WIDTH];
    logic [X_W-1:0]                    r_x;
    logic [Y_W-1:0]                    r_y;
    logic [DATA_WIDTH*KERNEL_SIZE-1:0] r_col_data;
    logic                              r_col_valid;
    logic [X_W-1:0]                    r_col_x;
    logic                              r_col_eol;
    logic                              r_frame_done;

    logic                              w_accept;
    logic                              w_last_x;
    logic                              w_last_y;
    logic                              w_emit;
    logic [DATA_WIDTH*KERNEL_SIZE-1:0] w_col;

    assign in_ready   = rstn & ~clear & (~r_col_valid | col_ready);
    assign w_accept   = in_valid & in_ready;
    assign w_last_x   = (r_x == X_W'(IMG_WIDTH - 1));
    assign w_last_y   = (r_y == Y_W'(IMG_HEIGHT - 1));
    assign w_emit     = (r_y >= Y_W'(KERNEL_SIZE - 1));

    assign col_data   = r_col_data;
    assign col_valid  = r_col_valid;
    assign col_x      = r_col_x;
    assign col_eol    = r_col_eol;
    assign frame_done = r_frame_done;

    // Slot 0 holds the oldest line, the top slot is the live pixel.
    always_comb begin
        w_col = '0;
        for (int k = 0; k < int'(LINES); k++) begin
            w_col[k*DATA_WIDTH +: DATA_WIDTH] = r_mem[int'(LINES) - 1 - k][r_x];
        end
        w_col[LINES*DATA_WIDTH +: DATA_WIDTH] = in_data;
    end

    // Line store is deliberately unreset; its contents are only used once refilled.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[0][r_x] <= in_data;
            for (int j = 1; j < int'(LINES); j++) begin
                r_mem[j][r_x] <= r_mem[j-1][r_x];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_x          <= '0;
            r_y          <= '0;
            r_col_data   <= '0;
            r_col_valid  <= 1'b0;
            r_col_x      <= '0;
            r_col_eol    <= 1'b0;
            r_frame_done <= 1'b0;
        end else if (clear) begin
            r_x          <= '0;
            r_y          <= '0;
            r_col_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_accept) begin
                if (w_last_x) begin
                    r_x <= '0;
                    if (w_last_y) begin
                        r_y          <= '0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_y <= r_y + 1'b1;
                    end
                end else begin
                    r_x <= r_x + 1'b1;
                end
                if (w_emit) begin
                    r_col_data  <= w_col;
                    r_col_x     <= r_x;
                    r_col_eol   <= w_last_x;
                    r_col_valid <= 1'b1;
                end else if (col_ready) begin
                    r_col_valid <= 1'b0;
                end
            end else if (col_ready) begin
                r_col_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_line_buffer.sv
// Directed bench for conv_line_buffer with K=3, W=4, H=4 and pixel(x,y)=4y+x+1.
module tb_conv_line_buffer;

    localparam int unsigned K  = 3;
    localparam int unsigned DW = 8;
    localparam int unsigned W  = 4;
    localparam int unsigned H  = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          clear;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW*K-1:0] col_data;
    logic          col_valid;
    logic          col_ready;
    logic [1:0]    col_x;
    logic          col_eol;
    logic          frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [DW*K-1:0] got_data[$];
    logic [1:0]      got_x[$];
    logic            got_eol[$];
    int              col_cyc[$];
    int              acc_cyc[$];
    int              fd_cyc[$];

    conv_line_buffer #(
        .KERNEL_SIZE (K),
        .DATA_WIDTH  (DW),
        .IMG_WIDTH   (W),
        .IMG_HEIGHT  (H)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .clear      (clear),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .col_data   (col_data),
        .col_valid  (col_valid),
        .col_ready  (col_ready),
        .col_x      (col_x),
        .col_eol    (col_eol),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (in_valid && in_ready) acc_cyc.push_back(cyc);
        if (rstn && col_valid && col_ready) begin
            got_data.push_back(col_data);
            got_x.push_back(col_x);
            got_eol.push_back(col_eol);
            col_cyc.push_back(cyc);
        end
        if (frame_done) fd_cyc.push_back(cyc);
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW*K-1:0] exp_col(input int i, input int off);
        int x;
        int y;
        logic [DW*K-1:0] c;
        x = i % 4;
        y = 2 + i / 4;
        for (int k = 0; k < 3; k++) c[k*DW +: DW] = DW'(4 * (y - 2 + k) + x + 1 + off);
        return c;
    endfunction

    task automatic clear_logs();
        got_data.delete(); got_x.delete(); got_eol.delete();
        col_cyc.delete(); acc_cyc.delete(); fd_cyc.delete();
    endtask

    task automatic push(input logic [DW-1:0] d);
        int t = 0;
        in_data  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("push_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push_frame(input int off, input bit gap);
        for (int i = 0; i < 16; i++) begin
            push(DW'(i + 1 + off));
            if (gap) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_frames(input string tag, input int nfr, input bit timing);
        int ncol;
        ncol = nfr * 8;
        check({tag, "_ncols"}, 64'(got_data.size()), 64'(ncol));
        check({tag, "_nfd"}, 64'(fd_cyc.size()), 64'(nfr));
        for (int i = 0; i < ncol && i < got_data.size(); i++) begin
            check({tag, "_data"}, 64'(got_data[i]), 64'(exp_col(i % 8, (i / 8) * 100)));
            check({tag, "_x"}, 64'(got_x[i]), 64'(i % 4));
            check({tag, "_eol"}, 64'(got_eol[i]), 64'((i % 4) == 3));
            if (timing && acc_cyc.size() > (i / 8) * 16 + 8 + (i % 8))
                check({tag, "_lat"}, 64'(col_cyc[i]),
                      64'(acc_cyc[(i / 8) * 16 + 8 + (i % 8)] + 1));
        end
        if (fd_cyc.size() >= 1 && acc_cyc.size() >= 16)
            check({tag, "_fd_cyc"}, 64'(fd_cyc[0]), 64'(acc_cyc[15] + 1));
    endtask

    initial begin
        logic [DW*K-1:0] hold;
        int              t;
        rstn      = 1'b0;
        clear     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        col_ready = 1'b1;
        #12;
        check("rst_col_valid", 64'(col_valid), 64'd0);
        check("rst_col_data", 64'(col_data), 64'd0);
        check("rst_col_x", 64'(col_x), 64'd0);
        check("rst_col_eol", 64'(col_eol), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        idle(1);

        // 1: continuous frame
        clear_logs();
        push_frame(0, 1'b0);
        idle(4);
        check_frames("s1", 1, 1'b1);

        // 2: consumer stall
        clear_logs();
        fork
            push_frame(0, 1'b0);
            begin
                t = 0;
                @(negedge clk);
                while (!col_valid && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                check("s2_valid_seen", 64'(col_valid), 64'd1);
                @(posedge clk);
                #1;
                col_ready = 1'b0;
                @(negedge clk);
                repeat (3) begin
                    hold = exp_col(got_data.size(), 0);
                    check("s2_in_ready", 64'(in_ready), 64'd0);
                    check("s2_hold_data", 64'(col_data), 64'(hold));
                    check("s2_hold_x", 64'(col_x), 64'(got_data.size() % 4));
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                col_ready = 1'b1;
            end
        join
        idle(4);
        check_frames("s2", 1, 1'b0);

        // 3: in_valid toggling
        clear_logs();
        push_frame(0, 1'b1);
        idle(4);
        check_frames("s3", 1, 1'b1);

        // 4: async reset mid-line, after pixel (2,2)
        clear_logs();
        for (int i = 0; i < 11; i++) push(DW'(i + 1));
        rstn = 1'b0;
        #1;
        check("s4_rst_col_valid", 64'(col_valid), 64'd0);
        check("s4_rst_frame_done", 64'(frame_done), 64'd0);
        check("s4_rst_col_x", 64'(col_x), 64'd0);
        idle(2);
        rstn = 1'b1;
        idle(1);
        clear_logs();
        push_frame(0, 1'b0);
        idle(4);
        check_frames("s4", 1, 1'b1);

        // 5: clear while offering pixel (1,3)
        clear_logs();
        for (int i = 0; i < 13; i++) push(DW'(i + 1));
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'd14;
        @(negedge clk);
        check("s5_in_ready", 64'(in_ready), 64'd0);
        check("s5_accepts", 64'(acc_cyc.size()), 64'd13);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check("s5_col_valid", 64'(col_valid), 64'd0);
        check("s5_frame_done", 64'(frame_done), 64'd0);
        check("s5_fd_none", 64'(fd_cyc.size()), 64'd0);
        idle(1);
        clear_logs();
        push_frame(0, 1'b0);
        idle(4);
        check_frames("s5", 1, 1'b1);

        // 6: two frames back-to-back
        clear_logs();
        push_frame(0, 1'b0);
        push_frame(100, 1'b0);
        idle(4);
        check_frames("s6", 2, 1'b1);
        if (got_data.size() > 8) check("s6_f2_first", 64'(got_data[8]), 64'h6d6965);
        if (fd_cyc.size() == 2) check("s6_fd_gap", 64'(fd_cyc[1] - fd_cyc[0]), 64'd16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
